udp_csum_gen: RTL and testbench

UDP_CSUM_GEN -- requirements
Module: udp_csum_gen

---
 rtl/udp_csum_gen_pkg.sv | 23 ++
 rtl/udp_csum_fold.sv | 34 +++
 rtl/udp_csum_gen.sv | 134 +++++++++++++
 tb/tb_udp_csum_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/udp_csum_gen_pkg.sv
// Shared widths, FSM state type and the ones-complement carry fold for the UDP checksum path.
package udp_csum_gen_pkg;

  localparam int unsigned SUM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned N      = DATA_W / SUM_W;
  localparam int unsigned C_W    = $clog2(N);
  localparam int unsigned WIDE_W = SUM_W + C_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two-stage end-around carry: the second add can never carry out again.
  function automatic logic [SUM_W-1:0] fold(input logic [WIDE_W-1:0] wide);
    logic [SUM_W:0] s1;
    s1 = (SUM_W+1)'(wide[SUM_W-1:0]) + (SUM_W+1)'(wide[WIDE_W-1:SUM_W]);
    return s1[SUM_W-1:0] + SUM_W'(s1[SUM_W]);
  endfunction

endpackage

// File: rtl/udp_csum_fold.sv
// Combinational adder of one base word plus all SUM_W slices of a beat, folded back to SUM_W bits.
module udp_csum_fold #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SUM_W  = 16
) (
  input  logic [SUM_W-1:0]  base,
  input  logic [DATA_W-1:0] data,
  output logic [SUM_W-1:0]  sum_c
);
  import udp_csum_gen_pkg::*;

  localparam int unsigned NW = DATA_W / SUM_W;
  localparam int unsigned CW = $clog2(NW) + 1;
  localparam int unsigned WW = SUM_W + CW;

  logic [WW-1:0] wide_c;

  always_comb begin
    wide_c = WW'(base);
    for (int i = 0; i < int'(NW); i++) begin
      wide_c = wide_c + WW'(data[i*SUM_W +: SUM_W]);
    end
  end

  // Default geometry reuses the shared fold; other widths get an equivalent local fold.
  if (WW == WIDE_W && SUM_W == udp_csum_gen_pkg::SUM_W) begin : g_pkg_fold
    assign sum_c = fold(wide_c);
  end else begin : g_local_fold
    logic [SUM_W:0] s1_c;
    assign s1_c  = (SUM_W+1)'(wide_c[SUM_W-1:0]) + (SUM_W+1)'(wide_c[WW-1:SUM_W]);
    assign sum_c = s1_c[SUM_W-1:0] + SUM_W'(s1_c[SUM_W]);
  end

endmodule

// File: rtl/udp_csum_gen.sv
// UDP checksum generator: accumulates packet beats into a ones-complement sum and emits ~sum.
// Define UDP_CSUM_ZERO_FIX_EN to transmit a computed 0x0000 checksum as 0xFFFF.
module udp_csum_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SUM_W  = 16
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_start,
  input  logic                  in_last,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [DATA_W/8-1:0]   in_keep,
  input  logic [SUM_W-1:0]      in_seed,
  output logic                  csum_valid,
  input  logic                  csum_ready,
  output logic [SUM_W-1:0]      csum_data,
  output logic                  proto_err
);
  import udp_csum_gen_pkg::*;

  localparam int unsigned KW = DATA_W / 8;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic               csum_valid_q, csum_valid_d;
  logic [SUM_W-1:0]   csum_data_q, csum_data_d;
  logic               proto_err_q, proto_err_d;
  logic               in_ready_q, in_ready_d;

  logic [DATA_W-1:0]  data_masked_c;
  logic [SUM_W-1:0]   base_c;
  logic [SUM_W-1:0]   sum_c;
  logic [SUM_W-1:0]   csum_c;
  logic               accept_c;

  // Disabled bytes contribute zero, which also pads an odd-length tail.
  always_comb begin
    for (int b = 0; b < int'(KW); b++) begin
      data_masked_c[b*8 +: 8] = in_data[b*8 +: 8] & {8{in_keep[b]}};
    end
  end

  assign accept_c = in_valid && in_ready_q;
  assign base_c   = (state_q == IDLE || in_start) ? in_seed : acc_q;

  udp_csum_fold #(
    .DATA_W (DATA_W),
    .SUM_W  (SUM_W)
  ) u_fold (
    .base  (base_c),
    .data  (data_masked_c),
    .sum_c (sum_c)
  );

`ifdef UDP_CSUM_ZERO_FIX_EN
  assign csum_c = (sum_c == '1) ? '1 : ~sum_c;
`else
  assign csum_c = ~sum_c;
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      csum_valid_q <= 1'b0;
      csum_data_q  <= '0;
      proto_err_q  <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      csum_valid_q <= csum_valid_d;
      csum_data_q  <= csum_data_d;
      proto_err_q  <= proto_err_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    csum_valid_d = csum_valid_q;
    csum_data_d  = csum_data_q;
    proto_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (in_start) begin
            acc_d = sum_c;
            if (in_last) begin
              state_d      = DONE;
              csum_valid_d = 1'b1;
              csum_data_d  = csum_c;
            end else begin
              state_d = ACC;
            end
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end
      ACC: begin
        if (accept_c) begin
          // A restart inside a packet drops the old sum; base_c already selects in_seed.
          proto_err_d = in_start;
          acc_d       = sum_c;
          if (in_last) begin
            state_d      = DONE;
            csum_valid_d = 1'b1;
            csum_data_d  = csum_c;
          end
        end
      end
      DONE: begin
        if (csum_ready) begin
          state_d      = IDLE;
          csum_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d != DONE);
  end

  assign in_ready   = in_ready_q;
  assign csum_valid = csum_valid_q;
  assign csum_data  = csum_data_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_udp_csum_gen.sv
// Scoreboard bench for udp_csum_gen: expected checksums queued at stimulus, checked on csum_valid.
module tb_udp_csum_gen;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_start = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_keep = '0;
  logic [15:0] in_seed = '0;
  logic        csum_valid;
  logic        csum_ready = 1'b1;
  logic [15:0] csum_data;
  logic        proto_err;

  int total = 0;
  int bad = 0;
  int proto_cnt = 0;
  logic [15:0] exp_q[$];
  logic [31:0] pd[4];
  logic [3:0]  pk[4];

  udp_csum_gen #(.DATA_W(32), .SUM_W(16)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_start   (in_start),
    .in_last    (in_last),
    .in_data    (in_data),
    .in_keep    (in_keep),
    .in_seed    (in_seed),
    .csum_valid (csum_valid),
    .csum_ready (csum_ready),
    .csum_data  (csum_data),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain 32-bit sum of all words, folded once at the end.
  function automatic logic [15:0] model_csum(input logic [15:0] seed, input int n);
    logic [31:0] s;
    logic [31:0] m;
    logic [15:0] r;
    s = 32'(seed);
    for (int i = 0; i < n; i++) begin
      m = pd[i];
      for (int b = 0; b < 4; b++) if (!pk[i][b]) m[b*8 +: 8] = 8'h00;
      s = s + 32'(m[31:16]) + 32'(m[15:0]);
    end
    while (s[31:16] != 16'h0) s = 32'(s[15:0]) + 32'(s[31:16]);
    r = ~s[15:0];
`ifdef UDP_CSUM_ZERO_FIX_EN
    if (r == 16'h0000) r = 16'hFFFF;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (nreset && proto_err) proto_cnt++;
    if (nreset && csum_valid && csum_ready) begin
      if (exp_q.size() == 0) check("stale_csum", 32'(exp_q.size()), 32'd1);
      else check("csum", 32'(csum_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic s,
                            input logic l, input logic [15:0] seed);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(n), 32'd0);
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_start = s;
    in_last  = l;
    in_seed  = seed;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] seed, input int n);
    for (int i = 0; i < n; i++) drive_beat(pd[i], pk[i], i == 0, i == n - 1, seed);
  endtask

  task automatic single(input logic [31:0] d, input logic [3:0] k, input logic [15:0] exp);
    exp_q.push_back(exp);
    drive_beat(d, k, 1'b1, 1'b1, 16'h0000);
  endtask

  initial begin
    int p0;
    logic [15:0] held;
    int n;
    logic [15:0] sd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_csum_valid", 32'(csum_valid), 32'd0);
    check("rst_csum_data", 32'(csum_data), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    nreset = 1'b1;

    // Single beat, with one-cycle latency and in_ready low in DONE.
    exp_q.push_back(16'hFFFC);
    drive_beat(32'h00010002, 4'b1111, 1'b1, 1'b1, 16'h0000);
    @(negedge clk);
    check("latency_valid", 32'(csum_valid), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd0);

    single(32'hAABBCCDD, 4'b1000, 16'h55FF);

    pd[0] = 32'hFFFFFFFF; pk[0] = 4'b1111;
    pd[1] = 32'h00010000; pk[1] = 4'b1111;
    exp_q.push_back(16'hFFFE);
    send_pkt(16'h0000, 2);

`ifdef UDP_CSUM_ZERO_FIX_EN
    single(32'hFFFF0000, 4'b1111, 16'hFFFF);
`else
    single(32'hFFFF0000, 4'b1111, 16'h0000);
`endif

    // Backpressure: result must hold while csum_ready is low.
    @(posedge clk); #1 csum_ready = 1'b0;
    exp_q.push_back(16'h1234 ^ 16'hFFFF);
    drive_beat(32'h00000000, 4'b1111, 1'b1, 1'b1, 16'h1234);
    @(negedge clk);
    held = csum_data;
    check("stall_data0", 32'(held), 32'h0000EDCB);
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", 32'(csum_valid), 32'd1);
      check("stall_data", 32'(csum_data), 32'(held));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 csum_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_ack_valid", 32'(csum_valid), 32'd0);
    check("post_ack_in_ready", 32'(in_ready), 32'd1);

    // Beat without start while idle is dropped with one error pulse.
    p0 = proto_cnt;
    drive_beat(32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, 16'h0000);
    repeat (3) @(negedge clk);
    check("idle_nostart_valid", 32'(csum_valid), 32'd0);
    check("idle_nostart_proto", 32'(proto_cnt - p0), 32'd1);

    // Restart inside a packet: old sum discarded, new seed used.
    p0 = proto_cnt;
    drive_beat(32'h11112222, 4'b1111, 1'b1, 1'b0, 16'h0F0F);
    drive_beat(32'h33334444, 4'b1111, 1'b0, 1'b0, 16'h0000);
    exp_q.push_back(16'hEEE9);
    drive_beat(32'h00020003, 4'b1111, 1'b1, 1'b1, 16'h1111);
    repeat (3) @(negedge clk);
    check("restart_proto", 32'(proto_cnt - p0), 32'd1);

    // Reset mid-packet: no checksum for the partial packet.
    p0 = proto_cnt;
    drive_beat(32'h12345678, 4'b1111, 1'b1, 1'b0, 16'h5555);
    drive_beat(32'h9ABCDEF0, 4'b1111, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_valid", 32'(csum_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    nreset = 1'b1;
    exp_q.push_back(16'hEDCB);
    drive_beat(32'h00000000, 4'b1111, 1'b1, 1'b1, 16'h1234);
    repeat (3) @(negedge clk);
    check("midrst_proto", 32'(proto_cnt - p0), 32'd0);

    // Random packets with random tail byte enables.
    for (int t = 0; t < 20; t++) begin
      n  = $urandom_range(1, 4);
      sd = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        pd[i] = $urandom;
        pk[i] = 4'b1111;
      end
      case ($urandom_range(0, 3))
        0: pk[n-1] = 4'b1000;
        1: pk[n-1] = 4'b1100;
        2: pk[n-1] = 4'b1110;
        default: pk[n-1] = 4'b1111;
      endcase
      exp_q.push_back(model_csum(sd, n));
      send_pkt(sd, n);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
